// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame constants used by
// both the transmit and receive paths, and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int DEFAULT_DATA_BITS   = 8;
  localparam int DEFAULT_OVERSAMPLE  = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Width of a counter that must hold values 0 .. max_count-1 (never below 1 bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

  localparam int DEFAULT_TICK_CNT_W = cnt_width(DEFAULT_OVERSAMPLE);
  localparam int DEFAULT_BIT_CNT_W  = cnt_width(DEFAULT_DATA_BITS);

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-flop synchronizer for an asynchronous, idle-high input with a
// falling-edge detector on the synchronized value. All flops reset to 1 so a
// reset never manufactures an edge.
module uart_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer and keep one delayed copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1 by default). Samples the synchronized line on
// the decimator's tick_en, recovers frames and hands bytes out via valid/ready.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_en,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun,
  input  logic                 overrun_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TICK_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W  = cnt_width(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rxd_s;
  logic rxd_fall;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_err_q, framing_err_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done;
  logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_err_q, parity_err_d;
  logic                 stop_eval;
`endif

  uart_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rxd),
    .sync_o  (rxd_s),
    .fall_o  (rxd_fall)
  );

  // State, counters and output registers; everything returns to idle on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q  <= parity_bit_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Frame FSM: IDLE reacts to a line edge on any clk, other states only on ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    stop_eval    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rxd_fall) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick_en) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d   = '0;
            parity_bit_d = rxd_s;
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick_en) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
`ifdef UART_RX_PARITY_EN
            stop_eval  = 1'b1;
`endif
            if (rxd_s) begin
              frame_done = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output handshake, overrun tracking and single-cycle error pulses.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    overrun_d     = overrun_q;
    framing_err_d = stop_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = stop_eval & ((^shift_q) ^ parity_bit_q);
`endif
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
